// File: rtl/washingmachine_prog.sv
// washingmachine_prog
//   Parametrised coin-operated washing machine controller.
//   Programmes are selected one-hot on i_mode; each programme has per-phase
//   durations (seconds) in the packed SOAK/WASH/RINSE/SPIN tables, mode m at
//   [m*TIME_W +: TIME_W]. Zero-length phases are skipped, an open lid freezes
//   the running phase, and cancel while filling/washing drains through SPIN.
//
//   Optional macro LID_TIMEOUT_EN: adds output o_fault and a pause timer; a
//   lid left open LID_TIMEOUT_S seconds in PAUSE ends the cycle in DONE.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_lid              1 = lid open
//   i_start, i_cancel  level requests from the front panel
//   i_coin             one-cycle coin pulse
//   i_mode             one-hot programme select
//   o_idle .. o_done   registered state indicators
//   o_paused           run phase frozen by open lid
//   o_waterinlet       water valve (SOAK and RINSE only)
//   o_coinreturn       one-cycle refund pulse
//   o_fault            lid timeout (LID_TIMEOUT_EN only)
//   o_remaining        seconds left in the current phase, 0 outside run phases
module washingmachine_prog #(
    parameter int unsigned CLK_HZ        = 250,
    parameter int unsigned NUM_MODES     = 3,
    parameter int unsigned TIME_W        = 16,
    parameter int unsigned COINS_REQ     = 1,
    parameter logic [NUM_MODES*TIME_W-1:0] SOAK_TBL  = {16'd600, 16'd600, 16'd300},
    parameter logic [NUM_MODES*TIME_W-1:0] WASH_TBL  = {16'd1200, 16'd900, 16'd300},
    parameter logic [NUM_MODES*TIME_W-1:0] RINSE_TBL = {16'd900, 16'd600, 16'd300},
    parameter logic [NUM_MODES*TIME_W-1:0] SPIN_TBL  = {16'd300, 16'd300, 16'd300},
    parameter int unsigned LID_TIMEOUT_S = 60
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_lid,
    input  logic                 i_start,
    input  logic                 i_cancel,
    input  logic                 i_coin,
    input  logic [NUM_MODES-1:0] i_mode,
    output logic                 o_idle,
    output logic                 o_ready,
    output logic                 o_soak,
    output logic                 o_wash,
    output logic                 o_rinse,
    output logic                 o_spin,
    output logic                 o_done,
    output logic                 o_paused,
    output logic                 o_waterinlet,
    output logic                 o_coinreturn,
`ifdef LID_TIMEOUT_EN
    output logic                 o_fault,
`endif
    output logic [TIME_W-1:0]    o_remaining
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_SOAK, S_WASH, S_RINSE, S_SPIN, S_PAUSE, S_DONE
    } state_t;

    state_t               state_q, state_d;
    state_t               phase_q, phase_d;   // run phase being timed (held through PAUSE)
    state_t               first_ph, after_soak, after_wash, after_rinse, after_spin_drain, tgt;
    logic [NUM_MODES-1:0] mode_q, mode_d, mode_sel;
    logic [3:0]           coins_q, coins_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [TIME_W-1:0]    rem_q, rem_d;
    logic [TIME_W-1:0]    dur_soak, dur_wash, dur_rinse, dur_spin;
    logic                 coinret_d;
    logic                 run_step;
    logic                 tick;

`ifdef LID_TIMEOUT_EN
    localparam logic [31:0] LTO_LIMIT = 32'(LID_TIMEOUT_S * CLK_HZ);
    logic [31:0] lto_q, lto_d;
    logic        fault_d;
`endif

    function automatic logic [TIME_W-1:0] dur_of(input state_t s,
                                                 input logic [TIME_W-1:0] ds, dw, dr, dp);
        case (s)
            S_SOAK:  return ds;
            S_WASH:  return dw;
            S_RINSE: return dr;
            S_SPIN:  return dp;
            default: return '0;
        endcase
    endfunction

    // In READY the durations follow the live selector so the first phase can be
    // loaded on the same edge the mode is latched.
    always_comb begin
        mode_sel  = (state_q == S_READY) ? i_mode : mode_q;
        dur_soak  = '0;
        dur_wash  = '0;
        dur_rinse = '0;
        dur_spin  = '0;
        for (int unsigned m = 0; m < NUM_MODES; m++) begin
            if (mode_sel[m]) begin
                dur_soak  = dur_soak  | SOAK_TBL[m*TIME_W +: TIME_W];
                dur_wash  = dur_wash  | WASH_TBL[m*TIME_W +: TIME_W];
                dur_rinse = dur_rinse | RINSE_TBL[m*TIME_W +: TIME_W];
                dur_spin  = dur_spin  | SPIN_TBL[m*TIME_W +: TIME_W];
            end
        end
    end

    // Successor of each phase, skipping zero-length ones.
    always_comb begin
        after_spin_drain = (dur_spin  != '0) ? S_SPIN  : S_DONE;
        after_rinse      = after_spin_drain;
        after_wash       = (dur_rinse != '0) ? S_RINSE : after_rinse;
        after_soak       = (dur_wash  != '0) ? S_WASH  : after_wash;
        first_ph         = (dur_soak  != '0) ? S_SOAK  : after_soak;
    end

    assign tick = (presc_q == PW'(CLK_HZ - 1));

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        mode_d    = mode_q;
        coins_d   = coins_q;
        presc_d   = presc_q;
        rem_d     = rem_q;
        coinret_d = 1'b0;
        run_step  = 1'b0;
        tgt       = S_DONE;
`ifdef LID_TIMEOUT_EN
        lto_d     = lto_q;
        fault_d   = o_fault;
`endif

        case (state_q)
            S_IDLE: begin
                rem_d = '0;
                if (i_cancel && coins_q != 4'd0) begin
                    coinret_d = 1'b1;
                    coins_d   = 4'd0;
                end else if (i_coin) begin
                    if (coins_q + 4'd1 >= 4'(COINS_REQ)) begin
                        coins_d = 4'd0;
                        state_d = S_READY;
                    end else begin
                        coins_d = coins_q + 4'd1;
                    end
                end
            end
            S_READY: begin
                if (i_cancel) begin
                    coinret_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (i_start && !i_lid && $onehot(i_mode)) begin
                    mode_d  = i_mode;
                    presc_d = '0;
                    state_d = first_ph;
                    phase_d = first_ph;
                    rem_d   = dur_of(first_ph, dur_soak, dur_wash, dur_rinse, dur_spin);
`ifdef LID_TIMEOUT_EN
                    fault_d = 1'b0;
`endif
                end
            end
            S_SOAK, S_WASH, S_RINSE: begin
                if (i_cancel) begin
                    state_d = after_spin_drain;
                    phase_d = after_spin_drain;
                    presc_d = '0;
                    rem_d   = dur_of(after_spin_drain, dur_soak, dur_wash, dur_rinse, dur_spin);
                end else if (i_lid) begin
                    state_d = S_PAUSE;
`ifdef LID_TIMEOUT_EN
                    lto_d   = '0;
`endif
                end else begin
                    run_step = 1'b1;
                end
            end
            S_SPIN: begin
                if (i_lid) begin
                    state_d = S_PAUSE;
`ifdef LID_TIMEOUT_EN
                    lto_d   = '0;
`endif
                end else begin
                    run_step = 1'b1;
                end
            end
            S_PAUSE: begin
                // The lid-closing edge already counts, so the total delay
                // equals the number of cycles the lid was open.
                if (!i_lid) begin
                    run_step = 1'b1;
                end
`ifdef LID_TIMEOUT_EN
                else if (lto_q >= LTO_LIMIT - 32'd1) begin
                    state_d = S_DONE;
                    rem_d   = '0;
                    fault_d = 1'b1;
                end else begin
                    lto_d = lto_q + 32'd1;
                end
`endif
            end
            S_DONE: begin
                rem_d = '0;
                if (i_lid) begin
                    state_d = S_IDLE;
                    mode_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (run_step) begin
            state_d = phase_q;
            if (tick) begin
                presc_d = '0;
                if (rem_q == TIME_W'(1)) begin
                    case (phase_q)
                        S_SOAK:  tgt = after_soak;
                        S_WASH:  tgt = after_wash;
                        S_RINSE: tgt = after_rinse;
                        default: tgt = S_DONE;
                    endcase
                    state_d = tgt;
                    phase_d = tgt;
                    rem_d   = dur_of(tgt, dur_soak, dur_wash, dur_rinse, dur_spin);
                end else begin
                    rem_d = rem_q - TIME_W'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            phase_q      <= S_SOAK;
            mode_q       <= '0;
            coins_q      <= 4'd0;
            presc_q      <= '0;
            rem_q        <= '0;
            o_idle       <= 1'b1;
            o_ready      <= 1'b0;
            o_soak       <= 1'b0;
            o_wash       <= 1'b0;
            o_rinse      <= 1'b0;
            o_spin       <= 1'b0;
            o_done       <= 1'b0;
            o_paused     <= 1'b0;
            o_waterinlet <= 1'b0;
            o_coinreturn <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            mode_q       <= mode_d;
            coins_q      <= coins_d;
            presc_q      <= presc_d;
            rem_q        <= rem_d;
            o_idle       <= (state_d == S_IDLE);
            o_ready      <= (state_d == S_READY);
            o_soak       <= (state_d == S_SOAK)  || (state_d == S_PAUSE && phase_d == S_SOAK);
            o_wash       <= (state_d == S_WASH)  || (state_d == S_PAUSE && phase_d == S_WASH);
            o_rinse      <= (state_d == S_RINSE) || (state_d == S_PAUSE && phase_d == S_RINSE);
            o_spin       <= (state_d == S_SPIN)  || (state_d == S_PAUSE && phase_d == S_SPIN);
            o_done       <= (state_d == S_DONE);
            o_paused     <= (state_d == S_PAUSE);
            o_waterinlet <= (state_d == S_SOAK) || (state_d == S_RINSE);
            o_coinreturn <= coinret_d;
        end
    end

`ifdef LID_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lto_q   <= '0;
            o_fault <= 1'b0;
        end else begin
            lto_q   <= lto_d;
            o_fault <= fault_d;
        end
    end
`endif

    assign o_remaining = rem_q;

endmodule

// File: tb/tb_washingmachine_prog.sv
// Directed bench for washingmachine_prog. Instance dut: CLK_HZ=4, one coin,
// default tables. Instance dut2: CLK_HZ=4, two coins, mode-0 soak of zero.
// Both share the front-panel inputs.
module tb_washingmachine_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lid = 1'b0, start = 1'b0, cancel = 1'b0, coin = 1'b0;
    logic [2:0] mode = 3'b000;

    logic        o_idle, o_ready, o_soak, o_wash, o_rinse, o_spin, o_done;
    logic        o_paused, o_waterinlet, o_coinreturn;
    logic [15:0] o_remaining;
    logic        b_idle, b_ready, b_soak, b_wash, b_rinse, b_spin, b_done;
    logic        b_paused, b_waterinlet, b_coinreturn;
    logic [15:0] b_remaining;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    washingmachine_prog #(.CLK_HZ(4), .COINS_REQ(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_lid(lid), .i_start(start), .i_cancel(cancel),
        .i_coin(coin), .i_mode(mode),
        .o_idle(o_idle), .o_ready(o_ready), .o_soak(o_soak), .o_wash(o_wash),
        .o_rinse(o_rinse), .o_spin(o_spin), .o_done(o_done), .o_paused(o_paused),
        .o_waterinlet(o_waterinlet), .o_coinreturn(o_coinreturn), .o_remaining(o_remaining)
    );

    washingmachine_prog #(.CLK_HZ(4), .COINS_REQ(2),
                          .SOAK_TBL({16'd600, 16'd600, 16'd0})) dut2 (
        .i_clk(clk), .i_rst(rst), .i_lid(lid), .i_start(start), .i_cancel(cancel),
        .i_coin(coin), .i_mode(mode),
        .o_idle(b_idle), .o_ready(b_ready), .o_soak(b_soak), .o_wash(b_wash),
        .o_rinse(b_rinse), .o_spin(b_spin), .o_done(b_done), .o_paused(b_paused),
        .o_waterinlet(b_waterinlet), .o_coinreturn(b_coinreturn), .o_remaining(b_remaining)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1; lid = 1'b0; start = 1'b0; cancel = 1'b0; coin = 1'b0; mode = 3'b000;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic coin_pulse;
        coin = 1'b1;
        step(1);
        coin = 1'b0;
    endtask

    task automatic start_mode(input logic [2:0] m);
        mode  = m;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (o_done !== 1'b1 && cnt < 6000) begin
            step(1);
            cnt++;
        end
    endtask

    initial begin
        // reset state
        step(2);
        chk("rst_idle", o_idle, 1);
        chk("rst_ready", o_ready, 0);
        chk("rst_remaining", o_remaining, 0);
        chk("rst_water", o_waterinlet, 0);
        chk("rst_coinret", o_coinreturn, 0);
        rst = 1'b0;
        step(1);

        // full run, mode 0: 300 s per phase at 4 Hz = 1200 cycles each
        coin_pulse();
        chk("coin_ready", o_ready, 1);
        start_mode(3'b001);
        chk("soak_entry", o_soak, 1);
        chk("soak_rem", o_remaining, 300);
        chk("soak_water", o_waterinlet, 1);
        step(1199);
        chk("soak_last", o_soak, 1);
        step(1);
        chk("wash_entry", o_wash, 1);
        chk("wash_rem", o_remaining, 300);
        chk("wash_water", o_waterinlet, 0);
        step(1200);
        chk("rinse_entry", o_rinse, 1);
        chk("rinse_water", o_waterinlet, 1);
        step(1200);
        chk("spin_entry", o_spin, 1);
        step(1199);
        chk("spin_last", o_spin, 1);
        step(1);
        chk("done", o_done, 1);
        chk("done_rem", o_remaining, 0);
        step(5);
        chk("done_hold", o_done, 1);
        lid = 1'b1;
        step(1);
        lid = 1'b0;
        chk("done_lid_idle", o_idle, 1);

        // lid pause mid-WASH at remaining=150 for 32 cycles
        do_reset();
        coin_pulse();
        start_mode(3'b001);
        step(1800);
        chk("pre_pause_wash", o_wash, 1);
        chk("pre_pause_rem", o_remaining, 150);
        lid = 1'b1;
        step(1);
        chk("pause_flag", o_paused, 1);
        chk("pause_wash", o_wash, 1);
        chk("pause_water", o_waterinlet, 0);
        step(31);
        lid = 1'b0;
        chk("pause_frozen_rem", o_remaining, 150);
        chk("pause_still", o_paused, 1);
        wait_done(n);
        chk("pause_done_delay", n, 3000);
        lid = 1'b1;
        step(1);
        lid = 1'b0;

        // cancel in WASH drains through full SPIN
        do_reset();
        coin_pulse();
        start_mode(3'b001);
        step(1300);
        chk("cancel_pre_wash", o_wash, 1);
        cancel = 1'b1;
        step(1);
        cancel = 1'b0;
        chk("cancel_spin", o_spin, 1);
        chk("cancel_rem", o_remaining, 300);
        chk("cancel_water", o_waterinlet, 0);
        chk("cancel_no_refund", o_coinreturn, 0);
        wait_done(n);
        chk("cancel_done_time", n, 1200);

        // READY: zero / multi-hot modes rejected, one-hot mode 1 accepted
        do_reset();
        coin_pulse();
        start_mode(3'b000);
        chk("mode_zero_ready", o_ready, 1);
        start_mode(3'b011);
        chk("mode_multi_ready", o_ready, 1);
        chk("mode_multi_soak", o_soak, 0);
        start_mode(3'b010);
        chk("mode1_soak", o_soak, 1);
        chk("mode1_rem", o_remaining, 600);

        // two-coin unit: refund, count clear, skip of zero soak, async reset
        do_reset();
        coin_pulse();
        chk("c2_one_coin_idle", b_idle, 1);
        chk("c2_one_coin_ready", b_ready, 0);
        cancel = 1'b1;
        step(1);
        cancel = 1'b0;
        chk("c2_refund_pulse", b_coinreturn, 1);
        step(1);
        chk("c2_refund_end", b_coinreturn, 0);
        chk("c2_refund_idle", b_idle, 1);
        coin_pulse();
        chk("c2_count_cleared", b_ready, 0);
        coin_pulse();
        chk("c2_two_coins", b_ready, 1);
        start_mode(3'b001);
        chk("c2_skip_soak", b_soak, 0);
        chk("c2_direct_wash", b_wash, 1);
        chk("c2_wash_rem", b_remaining, 300);
        step(1200);
        chk("c2_rinse", b_rinse, 1);
        step(100);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_idle", b_idle, 1);
        chk("async_rst_rinse", b_rinse, 0);
        chk("async_rst_rem", b_remaining, 0);
        step(1);
        rst = 1'b0;
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
